// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg -- shared types for the two-port memory arbiter.
//   arb_state_e : FSM states (IDLE, CMD, RDWAIT)
//   arb_owner_e : which requester owns the outstanding transaction
//   AW_DEF/DW_DEF : default address/data widths
package mem_arbiter_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    RDWAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates an instruction-fetch port and a data port onto a
// single memory command interface, one transaction outstanding at a time.
//
// Ports
//   CLOCK_50, reset          : clock (rising edge), async active-high reset
//   if_req/if_addr           : fetch read request
//   if_rdata/if_done         : fetch read data, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata/d_be : data load/store request
//   d_rdata/d_done           : load data, one-cycle completion pulse
//   if_stall/d_stall         : req AND NOT done, per port
//   mem_req/we/addr/wdata/be : registered memory command, held until mem_ready
//   mem_ready/mem_rvalid/mem_rdata : memory accept and read return
//   busy                     : FSM not in IDLE
//
// Build option: define ARB_FAIRNESS_EN to let fetch win a contested grant
// after MAX_DSTREAK consecutive data grants taken while fetch was waiting.
// Without it, data has strict priority and fetch can starve.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int MAX_DSTREAK = 4
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_done,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_done,
  output logic            if_stall,
  output logic            d_stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int BW = DW / 8;

  arb_state_e     state_q, state_d;
  arb_owner_e     owner_q, owner_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_we_q, mem_we_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]  mem_be_q, mem_be_d;
  logic           if_done_q, if_done_d;
  logic           d_done_q, d_done_d;
  logic [DW-1:0]  if_rdata_q, if_rdata_d;
  logic [DW-1:0]  d_rdata_q, d_rdata_d;

  // A port whose done is pulsing this cycle has just been served; treating
  // it as ineligible keeps a held req from being granted twice.
  logic if_elig, d_elig, fair_force, pick_if;
  assign if_elig = if_req & ~if_done_q;
  assign d_elig  = d_req  & ~d_done_q;
  assign pick_if = if_elig & (~d_elig | fair_force);

`ifdef ARB_FAIRNESS_EN
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  logic [SW-1:0] streak_q, streak_d;

  assign fair_force = (streak_q == SW'(MAX_DSTREAK));

  // Counts data grants taken while fetch is asking; saturates at the limit.
  always_comb begin
    streak_d = streak_q;
    if (state_q == IDLE && (if_elig | d_elig)) begin
      if (pick_if || !if_req)           streak_d = '0;
      else if (!fair_force)             streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) streak_q <= '0;
    else       streak_q <= streak_d;
  end
`else
  assign fair_force = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (if_elig | d_elig) begin
          state_d   = CMD;
          mem_req_d = 1'b1;
          if (pick_if) begin
            owner_d     = OWN_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = '1;
          end else begin
            owner_d     = OWN_D;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_be;
          end
        end
      end
      CMD: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            // Writes complete on accept; no return phase.
            state_d = IDLE;
            if (owner_q == OWN_IF) if_done_d = 1'b1;
            else                   d_done_d  = 1'b1;
          end else begin
            state_d = RDWAIT;
          end
        end
      end
      RDWAIT: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end else begin
            d_rdata_d = mem_rdata;
            d_done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = if_req & ~if_done_q;
  assign d_stall   = d_req & ~d_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, BW = DW / 8, MAXS = 4;
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic CLOCK_50 = 1'b0, reset = 1'b1;
  logic if_req = 0, d_req = 0, d_we = 0, mem_ready = 0, mem_rvalid = 0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic [BW-1:0] d_be = '0;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic if_done, d_done, if_stall, d_stall, mem_req, mem_we, busy;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_DSTREAK(MAXS)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done), .if_stall(if_stall), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0, bad = 0;

  task automatic ck(input string name, input bit ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s at %0t", name, $time);
    end
  endtask

  bit t_act, t_acc, t_if, t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  logic [BW-1:0] t_be;
  bit m_ifd, m_dd;
  logic [DW-1:0] m_ifr, m_dr;
  int streak;

  task automatic model_reset();
    t_act = 0; t_acc = 0; t_if = 0; t_we = 0;
    t_addr = '0; t_wdata = '0; t_be = '0;
    m_ifd = 0; m_dd = 0; m_ifr = '0; m_dr = '0; streak = 0;
  endtask

  task automatic model_step();
    bit ei, ed, take_if, nifd, ndd;
    nifd = 0; ndd = 0;
    if (!t_act) begin
      ei = if_req && !m_ifd;
      ed = d_req && !m_dd;
      if (ei || ed) begin
        take_if = ei && (!ed || (FAIR && streak >= MAXS));
        t_act = 1; t_acc = 0; t_if = take_if;
        if (take_if) begin
          t_we = 0; t_addr = if_addr; t_be = '1; streak = 0;
        end else begin
          t_we = d_we; t_addr = d_addr; t_wdata = d_wdata; t_be = d_be;
          streak = if_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
        end
      end
    end else if (!t_acc) begin
      if (mem_ready) begin
        t_acc = 1;
        if (t_we) begin
          t_act = 0;
          if (t_if) nifd = 1; else ndd = 1;
        end
      end
    end else if (mem_rvalid) begin
      t_act = 0;
      if (t_if) begin m_ifr = mem_rdata; nifd = 1; end
      else      begin m_dr = mem_rdata;  ndd = 1;  end
    end
    m_ifd = nifd; m_dd = ndd;
  endtask

  task automatic cyc();
    @(posedge CLOCK_50);
    model_step();
    #1;
  endtask

  bit chk_en = 0;
  initial forever begin
    @(negedge CLOCK_50);
    if (chk_en) begin
      ck("mem_req", mem_req === (t_act && !t_acc));
      if (t_act && !t_acc) begin
        ck("mem_we", mem_we === t_we);
        ck("mem_addr", mem_addr === t_addr);
        ck("mem_be", mem_be === t_be);
        if (t_we) ck("mem_wdata", mem_wdata === t_wdata);
      end
      ck("busy", busy === t_act);
      ck("if_done", if_done === m_ifd);
      ck("d_done", d_done === m_dd);
      ck("if_rdata", if_rdata === m_ifr);
      ck("d_rdata", d_rdata === m_dr);
      ck("if_stall", if_stall === (if_req && !m_ifd));
      ck("d_stall", d_stall === (d_req && !m_dd));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    ck("rst mem_req", mem_req === 1'b0);
    ck("rst mem_we", mem_we === 1'b0);
    ck("rst busy", busy === 1'b0);
    ck("rst mem_addr", mem_addr === '0);
    ck("rst mem_be", mem_be === '0);
    ck("rst if_done", if_done === 1'b0);
    ck("rst d_rdata", d_rdata === '0);
    reset = 0;
    chk_en = 1;
    cyc();

    if_req = 1; if_addr = 32'h40; mem_ready = 1;
    cyc();
    ck("t1 mem_req", mem_req === 1'b1);
    ck("t1 mem_addr", mem_addr === 32'h40);
    ck("t1 mem_we", mem_we === 1'b0);
    ck("t1 mem_be", mem_be === 4'hF);
    cyc();
    ck("t1 accepted", mem_req === 1'b0);
    ck("t1 busy", busy === 1'b1);
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    cyc();
    mem_rvalid = 0;
    ck("t1 if_done", if_done === 1'b1);
    ck("t1 if_rdata", if_rdata === 32'hDEADBEEF);
    ck("t1 if_stall", if_stall === 1'b0);
    cyc();
    ck("t1 no regrant", mem_req === 1'b0);
    ck("t1 done once", if_done === 1'b0);
    cyc();
    ck("t1 regrant", mem_req === 1'b1);
    if_req = 0;
    cyc();
    mem_rvalid = 1; mem_rdata = 32'h0BADF00D;
    cyc();
    mem_rvalid = 0;
    ck("t1b if_rdata", if_rdata === 32'h0BADF00D);

    mem_ready = 0;
    if_req = 1; if_addr = 32'h100;
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h12345678; d_be = 4'hF;
    cyc();
    ck("t2 mem_we", mem_we === 1'b1);
    ck("t2 mem_addr", mem_addr === 32'h80);
    ck("t2 mem_wdata", mem_wdata === 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      cyc();
      ck("t2 hold req", mem_req === 1'b1);
      ck("t2 hold addr", mem_addr === 32'h80);
      ck("t2 hold wdata", mem_wdata === 32'h12345678);
      ck("t2 hold be", mem_be === 4'hF);
      ck("t2 no done", d_done === 1'b0);
    end
    mem_ready = 1;
    cyc();
    ck("t2 d_done", d_done === 1'b1);
    ck("t2 idle", busy === 1'b0);
    cyc();
    ck("t2 fetch addr", mem_addr === 32'h100);
    ck("t2 fetch we", mem_we === 1'b0);
    if_req = 0; d_req = 0; d_we = 0;
    cyc();
    mem_rvalid = 1; mem_rdata = 32'hA5A50001;
    cyc();
    mem_rvalid = 0;
    ck("t2 if_done", if_done === 1'b1);
    ck("t2 if_rdata", if_rdata === 32'hA5A50001);

    d_req = 1; d_we = 0; d_addr = 32'h20;
    cyc();
    d_req = 0;
    cyc();
    ck("t3 rdwait busy", busy === 1'b1);
    reset = 1;
    #2;
    reset = 0;
    model_reset();
    mem_rvalid = 1; mem_rdata = 32'h777;
    cyc();
    mem_rvalid = 0;
    ck("t3 d_done", d_done === 1'b0);
    ck("t3 busy", busy === 1'b0);
    ck("t3 d_rdata", d_rdata === '0);
    ck("t3 if_rdata", if_rdata === '0);
    ck("t3 mem_req", mem_req === 1'b0);

    for (int n = 0; n < 4000; n++) begin
      if (n < 600) begin
        if_req = 1; d_req = 1;
      end else begin
        if_req = ($urandom_range(0, 3) != 0);
        d_req  = ($urandom_range(0, 3) != 0);
      end
      d_we       = 1'($urandom);
      if_addr    = $urandom;
      d_addr     = $urandom;
      d_wdata    = $urandom;
      d_be       = BW'($urandom);
      mem_ready  = ($urandom_range(0, 2) != 0);
      mem_rvalid = 1'($urandom);
      mem_rdata  = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        reset = 1;
        #2;
        reset = 0;
        model_reset();
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
